// File: rtl/layer_stream_sequencer_pkg.sv
// Shared types for the layer-to-layer stream sequencer: FSM state encoding
// and an index-width helper that stays valid for single-neuron layers.
package layer_stream_sequencer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } seq_state_t;

  // $clog2(1) is 0, which would give a zero-width index; clamp to one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_stream_sequencer_if.sv
// Bus between upstream neurons, the sequencer and the downstream serial layer.
// The master modport is the sequencer itself; slave is the surrounding system.
interface layer_stream_sequencer_if #(
  parameter int NN = 10,
  parameter int DW = 16
);

  logic [NN-1:0]    in_valid;
  logic [NN*DW-1:0] in_data;
  logic             x_ready;
  logic             x_valid;
  logic [DW-1:0]    x_data;
  logic             busy;
  logic             frame_done;
  logic             overrun;

  modport master (
    input  in_valid, in_data, x_ready,
    output x_valid, x_data, busy, frame_done, overrun
  );

  modport slave (
    output in_valid, in_data, x_ready,
    input  x_valid, x_data, busy, frame_done, overrun
  );

endinterface

// File: rtl/layer_stream_sequencer.sv
// Gathers one result per upstream neuron into a buffer, then streams the
// frame serially (neuron 0 first) into the next layer with a ready handshake.
module layer_stream_sequencer
  import layer_stream_sequencer_pkg::*;
#(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input logic                      clk,
  input logic                      rst,
  layer_stream_sequencer_if.master bus
);

  localparam int            IW       = idx_width(NN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  seq_state_t           state_reg, state_next;
  logic [NN-1:0]        mask_reg, mask_next;
  logic [NN-1:0]        capture;
  logic [IW-1:0]        idx_reg, idx_next;
  logic                 frame_done_reg, frame_done_next;
  logic                 overrun_reg, overrun_next;
  logic [dataWidth-1:0] data_buf [NN];
  logic [dataWidth-1:0] in_slice [NN];

  generate
    for (genvar gi = 0; gi < NN; gi++) begin : g_slice
      assign in_slice[gi] = bus.in_data[gi*dataWidth +: dataWidth];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    mask_next       = mask_reg;
    idx_next        = idx_reg;
    capture         = '0;
    frame_done_next = 1'b0;
    overrun_next    = overrun_reg;
    case (state_reg)
      COLLECT: begin
        // A second pulse from a neuron already held is dropped, never overwritten.
        capture   = bus.in_valid & ~mask_reg;
        mask_next = mask_reg | bus.in_valid;
        if (|(bus.in_valid & mask_reg)) overrun_next = 1'b1;
        if (&mask_next) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        if (|bus.in_valid) overrun_next = 1'b1;
        if (bus.x_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next      = COLLECT;
            mask_next       = '0;
            idx_next        = '0;
            frame_done_next = 1'b1;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= COLLECT;
      mask_reg       <= '0;
      idx_reg        <= '0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mask_reg       <= mask_next;
      idx_reg        <= idx_next;
      frame_done_reg <= frame_done_next;
      overrun_reg    <= overrun_next;
    end
  end

  // Buffer contents are don't-care after reset; the mask says what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NN; k++) begin
      if (capture[k]) data_buf[k] <= in_slice[k];
    end
  end

  assign bus.x_valid    = (state_reg == SEND);
  assign bus.x_data     = (state_reg == SEND) ? data_buf[idx_reg] : '0;
  assign bus.busy       = (state_reg == SEND) | (|mask_reg);
  assign bus.frame_done = frame_done_reg;
  assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Directed scoreboard bench: expected stream values are queued as frames are
// driven and compared against every valid x_data beat.
module tb_layer_stream_sequencer;

  localparam int NN = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer_stream_sequencer_if #(.NN(NN), .DW(DW)) bus ();

  layer_stream_sequencer #(.NN(NN), .dataWidth(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            checks      = 0;
  int            failures    = 0;
  int            done_count  = 0;
  int            frame_xfers = 0;
  logic [DW-1:0] exp_q [$];

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endfunction

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.frame_done) begin
        chk("frame_done_after_last", 32'(frame_xfers), 32'(NN));
        frame_xfers = 0;
        done_count++;
      end
      if (bus.x_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_x_valid", 32'(bus.x_valid), 32'd0);
        end else begin
          chk("x_data", 32'(bus.x_data), 32'(exp_q[0]));
          if (bus.x_ready) begin
            void'(exp_q.pop_front());
            frame_xfers++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_full(input logic [DW-1:0] base);
    for (int k = 0; k < NN; k++) begin
      bus.in_data[k*DW +: DW] = base + DW'(k);
      exp_q.push_back(base + DW'(k));
    end
    bus.in_valid = '1;
    chk("pre_capture_x_valid", 32'(bus.x_valid), 32'd0);
    tick();
    bus.in_valid = '0;
    chk("first_x_valid", 32'(bus.x_valid), 32'd1);
    chk("first_x_data", 32'(bus.x_data), 32'(base));
  endtask

  task automatic wait_done(input int target, input int budget, input bit stall);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      bus.x_ready = stall ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      tick();
      if (done_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
    bus.x_ready = 1'b1;
    chk("frame_done_within_budget", 32'(ok), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    logic [DW-1:0] v;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.x_ready  = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("reset_x_valid", 32'(bus.x_valid), 32'd0);
    chk("reset_x_data", 32'(bus.x_data), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
    chk("reset_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b1;
    tick();

    // 1: whole frame in one cycle
    drive_full(16'h0100);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    wait_done(1, 30, 1'b0);
    repeat (3) tick();
    chk("t1_done_once", 32'(done_count), 32'd1);
    chk("t1_overrun", 32'(bus.overrun), 32'd0);
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);

    // 2: staggered arrival, neuron k at cycle 2k
    for (int k = 0; k < NN; k++) begin
      v = 16'h2000 + DW'(k * 17);
      bus.in_data[k*DW +: DW] = v;
      bus.in_valid    = '0;
      bus.in_valid[k] = 1'b1;
      if (k == NN - 1) begin
        for (int j = 0; j < NN; j++) exp_q.push_back(16'h2000 + DW'(j * 17));
      end
      tick();
      bus.in_valid = '0;
      if (k == 0) chk("t2_busy_partial", 32'(bus.busy), 32'd1);
      chk("t2_x_valid_after_capture", 32'(bus.x_valid), (k == NN - 1) ? 32'd1 : 32'd0);
      if (k != NN - 1) tick();
    end
    wait_done(2, 30, 1'b0);
    chk("t2_overrun", 32'(bus.overrun), 32'd0);

    // 3: x_ready pattern 1,0,0,1 during SEND
    drive_full(16'h3000);
    wait_done(3, 80, 1'b1);
    chk("t3_done_count", 32'(done_count), 32'd3);
    chk("t3_overrun", 32'(bus.overrun), 32'd0);

    // 4: neuron 3 pulses twice; second value must be dropped
    bus.in_data[3*DW +: DW] = 16'h4003;
    bus.in_valid = '0;
    bus.in_valid[3] = 1'b1;
    tick();
    chk("t4_overrun_before", 32'(bus.overrun), 32'd0);
    bus.in_data[3*DW +: DW] = 16'hDEAD;
    tick();
    chk("t4_overrun_set", 32'(bus.overrun), 32'd1);
    for (int k = 0; k < NN; k++) begin
      if (k != 3) bus.in_data[k*DW +: DW] = 16'h4000 + DW'(k);
      exp_q.push_back(16'h4000 + DW'(k));
    end
    bus.in_valid = '1;
    bus.in_valid[3] = 1'b0;
    tick();
    bus.in_valid = '0;
    wait_done(4, 30, 1'b0);
    chk("t4_overrun_sticky", 32'(bus.overrun), 32'd1);

    // 5: reset while idx==4 in SEND
    drive_full(16'h5000);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_xfers >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_reach_idx4", 32'(ok), 32'd1);
    chk("t5_x_data_idx4", 32'(bus.x_data), 32'h5004);
    rst = 1'b0;
    #1;
    chk("t5_rst_x_valid", 32'(bus.x_valid), 32'd0);
    chk("t5_rst_x_data", 32'(bus.x_data), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("t5_rst_overrun", 32'(bus.overrun), 32'd0);
    exp_q.delete();
    frame_xfers = 0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("t5_no_done_on_abort", 32'(done_count), 32'd4);
    drive_full(16'h6000);
    wait_done(5, 30, 1'b0);

    // 6: back-to-back frames, second presented in the frame_done cycle
    drive_full(16'h7000);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t6_first_done_seen", 32'(ok), 32'd1);
    drive_full(16'h8000);
    wait_done(7, 30, 1'b0);
    chk("t6_done_count", 32'(done_count), 32'd7);
    chk("t6_overrun", 32'(bus.overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
